// File: rtl/multiaddr_fork_seq.sv
// multiaddr_fork_seq: multicast-to-unicast request sequencer with joined response; MULTIADDR_FORK_SEQ_STATS_EN adds request/unicast/error counters
module multiaddr_fork_seq #(
  parameter int unsigned NoIndices = 4,
  parameter int unsigned NoRules = 4,
  parameter type addr_t = logic [15:0]
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NoRules*(32+2*$bits(addr_t))-1:0] addr_map_i,
  input  logic                                    req_valid_i,
  output logic                                    req_ready_o,
  input  logic [$bits(addr_t)-1:0]                req_addr_i,
  input  logic [$bits(addr_t)-1:0]                req_mask_i,
  output logic                                    dst_valid_o,
  input  logic                                    dst_ready_i,
  output logic [$clog2(NoIndices)-1:0]            dst_idx_o,
  output logic [$bits(addr_t)-1:0]                dst_addr_o,
  output logic [$bits(addr_t)-1:0]                dst_mask_o,
  input  logic                                    dst_rsp_valid_i,
  input  logic                                    dst_rsp_err_i,
  output logic                                    dst_rsp_ready_o,
  output logic                                    rsp_valid_o,
  output logic                                    rsp_err_o,
  input  logic                                    rsp_ready_i,
  output logic                                    busy_o
`ifdef MULTIADDR_FORK_SEQ_STATS_EN
  ,
  output logic [31:0]                             stat_req_o,
  output logic [31:0]                             stat_unicast_o,
  output logic [31:0]                             stat_err_o
`endif
);
  localparam int unsigned IdxWidth = $clog2(NoIndices);
  localparam int unsigned CntWidth = $clog2(NoIndices + 1);
  typedef struct packed {
    int unsigned idx;
    addr_t       addr;
    addr_t       mask;
  } rule_t;
  typedef enum logic [1:0] {IDLE, DISPATCH, COLLECT, RESPOND} state_e;
  rule_t [NoRules-1:0]   rules;
  state_e                state;
  logic [NoIndices-1:0]  pending, pending_n, sel;
  logic [CntWidth-1:0]   cnt, cnt_n, sel_cnt;
  logic                  err, acc, disp, rsp;
  logic [IdxWidth-1:0]   low_idx;
  addr_t [NoIndices-1:0] addr_q, mask_q, res_addr, res_mask;
  assign rules = addr_map_i;
  // Decode the request against every rule; later rules win the resolved payload for a shared index
  always_comb begin
    sel = '0;
    res_addr = '0;
    res_mask = '0;
    for (int r = 0; r < NoRules; r++)
      if (rules[r].idx < NoIndices && &((req_mask_i | rules[r].mask) | ~(req_addr_i ^ rules[r].addr))) begin
        sel[rules[r].idx[IdxWidth-1:0]] = 1'b1;
        res_addr[rules[r].idx[IdxWidth-1:0]] = (~req_mask_i & req_addr_i) | (req_mask_i & rules[r].addr);
        res_mask[rules[r].idx[IdxWidth-1:0]] = req_mask_i & rules[r].mask;
      end
  end
  // Destination count of the incoming request and lowest still-pending index
  always_comb begin
    sel_cnt = '0;
    low_idx = '0;
    for (int i = 0; i < NoIndices; i++) sel_cnt = sel_cnt + CntWidth'(sel[i]);
    for (int i = NoIndices - 1; i >= 0; i--) if (pending[i]) low_idx = IdxWidth'(i);
  end
  assign req_ready_o = state == IDLE;
  assign dst_valid_o = state == DISPATCH;
  assign dst_rsp_ready_o = state == DISPATCH || state == COLLECT;
  assign rsp_valid_o = state == RESPOND;
  assign rsp_err_o = rsp_valid_o & err;
  assign busy_o = state != IDLE;
  assign dst_idx_o = dst_valid_o ? low_idx : '0;
  assign dst_addr_o = dst_valid_o ? addr_q[low_idx] : '0;
  assign dst_mask_o = dst_valid_o ? mask_q[low_idx] : '0;
  assign acc = req_valid_i & req_ready_o;
  assign disp = dst_valid_o & dst_ready_i;
  assign rsp = dst_rsp_valid_i & dst_rsp_ready_o;
  assign pending_n = disp ? pending & ~(NoIndices'(1) << low_idx) : pending;
  assign cnt_n = (rsp && cnt != '0) ? cnt - CntWidth'(1) : cnt;
  // Sequencer: accept, fan out one unicast at a time, count responses back, then answer upstream
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      pending <= '0;
      cnt <= '0;
      err <= 1'b0;
      addr_q <= '0;
      mask_q <= '0;
    end else begin
      pending <= pending_n;
      cnt <= cnt_n;
      err <= err | (rsp & dst_rsp_err_i);
      case (state)
        IDLE: if (acc) begin
          pending <= sel;
          addr_q <= res_addr;
          mask_q <= res_mask;
          cnt <= sel_cnt;
          err <= ~|sel;
          state <= |sel ? DISPATCH : RESPOND;
        end
        DISPATCH: if (disp && pending_n == '0) state <= cnt_n == '0 ? RESPOND : COLLECT;
        COLLECT: if (rsp && cnt == CntWidth'(1)) state <= RESPOND;
        RESPOND: if (rsp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
`ifdef MULTIADDR_FORK_SEQ_STATS_EN
  // Saturating activity counters
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      stat_req_o <= '0;
      stat_unicast_o <= '0;
      stat_err_o <= '0;
    end else begin
      if (acc && ~&stat_req_o) stat_req_o <= stat_req_o + 32'd1;
      if (disp && ~&stat_unicast_o) stat_unicast_o <= stat_unicast_o + 32'd1;
      if (rsp_valid_o && rsp_ready_i && err && ~&stat_err_o) stat_err_o <= stat_err_o + 32'd1;
    end
`endif
`ifndef SYNTHESIS
  a_rsp_outstanding: assert property (@(posedge clk_i) disable iff (rst_i) !(rsp && cnt == '0))
    else $error("downstream response with no outstanding dispatch");
`endif
endmodule

// File: tb/tb_multiaddr_fork_seq.sv
// tb_multiaddr_fork_seq: table-driven and randomized checks of multiaddr_fork_seq against a rule-level model
module tb_multiaddr_fork_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_i, req_valid_i, req_ready_o, dst_valid_o, dst_ready_i;
  logic dst_rsp_valid_i, dst_rsp_err_i, dst_rsp_ready_o, rsp_valid_o, rsp_err_o, rsp_ready_i, busy_o;
  logic [255:0] addr_map;
  logic [15:0] req_addr_i, req_mask_i, dst_addr_o, dst_mask_o;
  logic [1:0] dst_idx_o;
  logic [31:0] stat_req, stat_uni, stat_err;
  multiaddr_fork_seq dut (
    .clk_i(clk), .rst_i(rst_i), .addr_map_i(addr_map),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i), .req_mask_i(req_mask_i),
    .dst_valid_o(dst_valid_o), .dst_ready_i(dst_ready_i), .dst_idx_o(dst_idx_o),
    .dst_addr_o(dst_addr_o), .dst_mask_o(dst_mask_o),
    .dst_rsp_valid_i(dst_rsp_valid_i), .dst_rsp_err_i(dst_rsp_err_i), .dst_rsp_ready_o(dst_rsp_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_ready_i(rsp_ready_i), .busy_o(busy_o)
`ifdef MULTIADDR_FORK_SEQ_STATS_EN
    , .stat_req_o(stat_req), .stat_unicast_o(stat_uni), .stat_err_o(stat_err)
`endif
  );
`ifndef MULTIADDR_FORK_SEQ_STATS_EN
  assign stat_req = '0;
  assign stat_uni = '0;
  assign stat_err = '0;
`endif
  typedef struct {
    int idx;
    logic [15:0] addr, mask;
  } disp_t;
  typedef struct {
    logic [15:0] a, m;
    int sidx, scyc;
    logic [3:0] errs;
    int rdy, rsp, n;
    logic e;
  } vec_t;
  int total = 0, bad = 0;
  int exp_req = 0, exp_uni = 0, exp_err = 0;
  int unsigned r_idx[4];
  logic [15:0] r_addr[4], r_mask[4];
  disp_t exp_q[$];
  vec_t vt[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic set_map();
    for (int i = 0; i < 4; i++) addr_map[i*64 +: 64] = {r_idx[i], r_addr[i], r_mask[i]};
  endtask
  // Reference: for each destination in ascending order, the last matching rule for it defines the payload
  task automatic build_exp(input logic [15:0] a, input logic [15:0] m);
    logic hit;
    disp_t e;
    exp_q.delete();
    for (int d = 0; d < 4; d++) begin
      hit = 1'b0;
      e = '{0, 16'h0, 16'h0};
      for (int r = 0; r < 4; r++)
        if (r_idx[r] == d && ((a ^ r_addr[r]) & ~(m | r_mask[r])) == 16'h0) begin
          hit = 1'b1;
          e = '{d, (a & ~m) | (r_addr[r] & m), m & r_mask[r]};
        end
      if (hit) exp_q.push_back(e);
    end
  endtask
  task automatic txn(input vec_t v);
    int k, nrsp, stall;
    logic hs, rh, done;
    k = 0;
    nrsp = 0;
    stall = 0;
    done = 1'b0;
    build_exp(v.a, v.m);
    chk("req_ready", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_addr_i = v.a;
    req_mask_i = v.m;
    @(posedge clk);
    exp_req++;
    @(negedge clk);
    req_valid_i = 1'b0;
    req_addr_i = 16'($urandom);
    req_mask_i = 16'($urandom);
    chk("first_dst_valid", dst_valid_o, v.n != 0);
    for (int c = 0; c < 300 && !done; c++) begin
      chk("busy", busy_o, 1);
      if (k == v.n && nrsp == v.n) chk("rsp_valid", rsp_valid_o, 1);
      else chk("rsp_early", rsp_valid_o, 0);
      if (rsp_valid_o) chk("rsp_err", rsp_err_o, v.e);
      chk("dst_rsp_ready", dst_rsp_ready_o, !rsp_valid_o);
      if (dst_valid_o) begin
        if (k < exp_q.size()) begin
          chk("dst_idx", dst_idx_o, exp_q[k].idx);
          chk("dst_addr", dst_addr_o, exp_q[k].addr);
          chk("dst_mask", dst_mask_o, exp_q[k].mask);
        end else chk("extra_dispatch", dst_valid_o, 0);
      end
      if (dst_valid_o && int'(dst_idx_o) == v.sidx && stall < v.scyc) begin
        dst_ready_i = 1'b0;
        stall++;
      end else dst_ready_i = $urandom_range(99) < v.rdy;
      hs = dst_valid_o & dst_ready_i;
      dst_rsp_valid_i = (k + int'(hs) > nrsp) && $urandom_range(99) < v.rsp;
      dst_rsp_err_i = (dst_rsp_valid_i && nrsp < 4) ? v.errs[nrsp] : 1'b0;
      rh = dst_rsp_valid_i & dst_rsp_ready_o;
      rsp_ready_i = 1'($urandom_range(1));
      done = rsp_valid_o & rsp_ready_i;
      @(posedge clk);
      k += int'(hs);
      exp_uni += int'(hs);
      nrsp += int'(rh);
      @(negedge clk);
    end
    dst_ready_i = 1'b0;
    dst_rsp_valid_i = 1'b0;
    dst_rsp_err_i = 1'b0;
    rsp_ready_i = 1'b0;
    chk("rsp_done", done, 1);
    chk("n_dispatch", k, v.n);
    chk("idle_busy", busy_o, 0);
    chk("idle_ready", req_ready_o, 1);
    chk("idle_rsp", rsp_valid_o, 0);
    if (done && v.e) exp_err++;
  endtask
  task automatic chk_reset_outputs();
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_dst_valid", dst_valid_o, 0);
    chk("rst_dst_idx", dst_idx_o, 0);
    chk("rst_dst_addr", dst_addr_o, 0);
    chk("rst_dst_mask", dst_mask_o, 0);
    chk("rst_dst_rsp_ready", dst_rsp_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_busy", busy_o, 0);
  endtask
  initial begin
    vec_t rv;
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i = '0;
    req_mask_i = '0;
    dst_ready_i = 1'b0;
    dst_rsp_valid_i = 1'b0;
    dst_rsp_err_i = 1'b0;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r_idx[i] = i;
      r_addr[i] = 16'(i << 12);
      r_mask[i] = 16'h0FFF;
    end
    set_map();
    vt[0] = '{16'h0010, 16'h3000, -1, 0, 4'b0000, 100, 100, 4, 1'b0};
    vt[1] = '{16'h4000, 16'h0000, -1, 0, 4'b0000, 100, 100, 0, 1'b1};
    vt[2] = '{16'h0010, 16'h3000, 1, 3, 4'b0010, 100, 50, 4, 1'b1};
    vt[3] = '{16'h1234, 16'h0000, -1, 0, 4'b0000, 100, 100, 1, 1'b0};
    vt[4] = '{16'h2ABC, 16'h0000, -1, 0, 4'b0001, 60, 60, 1, 1'b1};
    vt[5] = '{16'h0FFF, 16'hFFFF, -1, 0, 4'b0000, 50, 30, 4, 1'b0};
    #1 chk_reset_outputs();
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) txn(vt[i]);
    req_valid_i = 1'b1;
    req_addr_i = 16'h0010;
    req_mask_i = 16'h3000;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    dst_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #2 chk("pre_rst_dst_valid", dst_valid_o, 1);
    chk("pre_rst_dst_idx", dst_idx_o, 2);
    rst_i = 1'b1;
    #1 chk_reset_outputs();
    exp_req = 0;
    exp_uni = 0;
    exp_err = 0;
    dst_ready_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    txn(vt[0]);
    txn(vt[1]);
    for (int t = 0; t < 60; t++) begin
      if (t % 10 == 0) begin
        for (int i = 0; i < 4; i++) begin
          r_idx[i] = $urandom_range(3);
          r_addr[i] = 16'($urandom);
          r_mask[i] = 16'($urandom & $urandom);
        end
        set_map();
      end
      rv.a = r_addr[$urandom_range(3)] ^ 16'($urandom & $urandom & $urandom);
      rv.m = 16'($urandom & $urandom & $urandom);
      rv.sidx = $urandom_range(3);
      rv.scyc = $urandom_range(3);
      rv.errs = 4'($urandom);
      rv.rdy = $urandom_range(100, 20);
      rv.rsp = $urandom_range(100, 20);
      build_exp(rv.a, rv.m);
      rv.n = exp_q.size();
      rv.e = rv.n == 0 ? 1'b1 : |(rv.errs & 4'((1 << rv.n) - 1));
      txn(rv);
    end
`ifdef MULTIADDR_FORK_SEQ_STATS_EN
    chk("stat_req", stat_req, exp_req);
    chk("stat_unicast", stat_uni, exp_uni);
    chk("stat_err", stat_err, exp_err);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multiaddr_fork_seq.md
Name: multiaddr_fork_seq

Overview:
- Multicast request sequencer built around the multi-address decode function.
- Accepts one {addr, mask} request and decodes it against a rule map. Dispatches one unicast request per matching index, one at a time, on a shared downstream port.
- Joins the per-destination responses into a single upstream response with OR-ed error.
- Sits between a multicast-capable initiator and an interconnect that only supports unicast.

Parameters:
- NoIndices, 4: number of destination indices; must be >= 2.
- NoRules, 4: number of address map rules; must be >= 1.
- addr_t, logic[15:0]: address/mask type.
- rule_t, logic: packed struct {int unsigned idx; addr_t addr; addr_t mask}; idx < NoIndices.
- IdxWidth, $clog2(NoIndices): derived; width of dst_idx_o.
- CntWidth, $clog2(NoIndices+1): derived; width of the response counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous active-high reset.
- addr_map_i  in  NoRules*$bits(rule_t)  rule map; must be stable from request acceptance until the response handshake.
- req_valid_i  in  1  upstream request valid.
- req_ready_o  out  1  upstream request ready.
- req_addr_i  in  $bits(addr_t)  request address.
- req_mask_i  in  $bits(addr_t)  request don't-care mask.
- dst_valid_o  out  1  downstream unicast valid.
- dst_ready_i  in  1  downstream unicast ready.
- dst_idx_o  out  IdxWidth  destination index.
- dst_addr_o  out  $bits(addr_t)  resolved address for dst_idx_o.
- dst_mask_o  out  $bits(addr_t)  resolved mask for dst_idx_o.
- dst_rsp_valid_i  in  1  downstream response valid.
- dst_rsp_err_i  in  1  downstream response error.
- dst_rsp_ready_o  out  1  downstream response ready.
- rsp_valid_o  out  1  joined response valid.
- rsp_err_o  out  1  joined response error.
- rsp_ready_i  in  1  joined response ready.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Decode rules (combinational on req_addr_i/req_mask_i):
  - rule i matches iff &((req_mask_i | rule.mask) | ~(req_addr_i ^ rule.addr)).
  - select[idx] is the OR over all matching rules with that idx.
  - Resolved mask = req_mask_i & rule.mask.
  - Resolved addr = (~req_mask_i & req_addr_i) | (req_mask_i & rule.addr).
  - Several matching rules with the same idx: the highest-numbered rule supplies the resolved addr/mask.
- State machine: IDLE, DISPATCH, COLLECT, RESPOND.
- Reset values: state=IDLE, pending='0, cnt='0, err=0, all per-index addr/mask registers '0.
- Output values at reset: req_ready_o=1, dst_valid_o=0, dst_idx_o/dst_addr_o/dst_mask_o='0, dst_rsp_ready_o=0, rsp_valid_o=0, rsp_err_o=0, busy_o=0.
- IDLE:
  - req_ready_o=1.
  - On handshake, register select into pending, the resolved addr/mask per index, and cnt=popcount(select); clear err.
  - No match: err=1, go to RESPOND.
  - Otherwise go to DISPATCH.
- DISPATCH:
  - dst_valid_o=1; dst_idx_o = lowest set bit of pending; dst_addr_o/dst_mask_o come from that index's registers.
  - Payload holds stable until dst_ready_i.
  - On handshake, clear that pending bit.
  - When the last bit clears, go to COLLECT. If cnt is already 0 after this cycle's response accounting, go to RESPOND instead.
- Responses:
  - dst_rsp_ready_o=1 in DISPATCH and COLLECT, 0 otherwise.
  - Each response handshake decrements cnt and ORs dst_rsp_err_i into err.
  - A dispatch handshake and a response handshake in the same cycle are both honoured.
- COLLECT: a response handshake with cnt==1 moves to RESPOND.
- RESPOND:
  - rsp_valid_o=1, rsp_err_o=err; both hold until rsp_ready_i.
  - On handshake go to IDLE; a new request can be accepted the following cycle at the earliest.
- Latency:
  - First dst_valid_o is asserted the cycle after request acceptance.
  - A no-match response is asserted the cycle after acceptance.
- Asynchronous reset mid-operation returns all state to reset values immediately. In-flight dispatches are abandoned, with no response generated.
- Protocol violation: a response with cnt==0 is flagged by a simulation-only assertion. cnt saturates at 0.

Optional Feature:
- Macro: MULTIADDR_FORK_SEQ_STATS_EN.
- Defined: adds outputs stat_req_o[31:0], stat_unicast_o[31:0] and stat_err_o[31:0].
  - stat_req_o counts accepted requests.
  - stat_unicast_o counts dispatch handshakes.
  - stat_err_o counts joined responses with err=1.
  - All three saturate at 32'hFFFF_FFFF and reset to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Setup: rules idx0..3 at addr 0x0000/0x1000/0x2000/0x3000, mask 0x0FFF. Request addr 0x0010, mask 0x3000, dst_ready_i=1 -> four dispatches on consecutive cycles with idx 0,1,2,3, addr 0x0010/0x1010/0x2010/0x3010, mask 0x0000; four OK responses -> rsp_valid_o=1, rsp_err_o=0.
- Request addr 0x4000, mask 0x0000 (no match) -> no dst_valid_o; rsp_valid_o=1, rsp_err_o=1 one cycle after acceptance.
- Same multicast with dst_ready_i low for 3 cycles on idx 1 -> idx 1 payload held stable; order stays 0,1,2,3. Response 2 arrives with err=1 -> rsp_err_o=1 only after all 4 responses.
- Request addr 0x1234, mask 0x0000 -> single dispatch idx1, addr 0x1234, mask 0x0000. Response arrives in the same cycle as the dispatch handshake -> next state RESPOND.
- rst_i asserted during DISPATCH after 2 of 4 dispatches -> all outputs at reset values immediately; a new request afterwards completes normally.
- Stats build, 3 requests (one no-match) -> stat_req_o=3, stat_err_o=1, stat_unicast_o equals the total number of dispatches.
